multi_timeout: RTL and testbench



---
 rtl/multi_timeout.sv | 161 ++++++++++++++++
 tb/tb_multi_timeout.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_timeout.sv
// Multi-channel timeout/watchdog bank: a shared prescaler tick drives N independent channels.
// Define MULTI_TIMEOUT_IRQ_EN to add maskable, acknowledgeable interrupt status per channel.
module multi_timeout #(
    parameter int unsigned CHANNELS    = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned PRESC_WIDTH = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [PRESC_WIDTH-1:0]    i_presc,
    input  logic [CHANNELS-1:0]       i_enable,
    input  logic [CHANNELS-1:0]       i_clear,
    input  logic [CHANNELS-1:0]       i_mode,
    input  logic [CHANNELS*WIDTH-1:0] i_limit,
`ifdef MULTI_TIMEOUT_IRQ_EN
    input  logic [CHANNELS-1:0]       i_irq_mask,
    input  logic [CHANNELS-1:0]       i_irq_ack,
    output logic [CHANNELS-1:0]       o_irq_status,
    output logic                      o_irq,
`endif
    output logic [CHANNELS*WIDTH-1:0] o_count,
    output logic [CHANNELS-1:0]       o_timeout,
    output logic [CHANNELS-1:0]       o_pulse
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StExpired
    } state_e;

    localparam logic [PRESC_WIDTH-1:0] PrescOne = PRESC_WIDTH'(1);
    localparam logic [WIDTH:0]         CountOne = (WIDTH + 1)'(1);

    logic [PRESC_WIDTH-1:0] presc_q, presc_d;
    logic                   tick;

    // Equality compare: if i_presc drops below the counter it wraps through zero first.
    always_comb begin
        tick    = (presc_q == i_presc);
        presc_d = tick ? '0 : presc_q + PrescOne;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
        end else begin
            presc_q <= presc_d;
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        state_e           state_q, state_d;
        logic [WIDTH-1:0] count_q, count_d;
        logic [WIDTH-1:0] limit;
        logic [WIDTH:0]   count_inc;
        logic             timeout_q, timeout_d;
        logic             pulse_q, pulse_d;
        logic             expire;

        assign limit = i_limit[c*WIDTH +: WIDTH];

        always_comb begin
            state_d   = state_q;
            count_d   = count_q;
            timeout_d = timeout_q;
            pulse_d   = 1'b0;
            // One extra bit so count+1 never wraps before the limit compare.
            count_inc = {1'b0, count_q} + CountOne;
            expire    = (limit != '0) && (count_inc >= {1'b0, limit});

            if (!i_enable[c]) begin
                state_d   = StIdle;
                count_d   = '0;
                timeout_d = 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        state_d = StRun;
                        count_d = '0;
                    end
                    StRun: begin
                        if (i_clear[c]) begin
                            count_d = '0;
                        end else if (tick) begin
                            if (limit == '0) begin
                                count_d = '0;
                            end else if (expire) begin
                                pulse_d = 1'b1;
                                if (i_mode[c]) begin
                                    count_d = '0;
                                end else begin
                                    count_d   = limit;
                                    state_d   = StExpired;
                                    timeout_d = 1'b1;
                                end
                            end else begin
                                count_d = count_inc[WIDTH-1:0];
                            end
                        end
                    end
                    StExpired: begin
                        if (i_clear[c]) begin
                            count_d   = '0;
                            timeout_d = 1'b0;
                            state_d   = StRun;
                        end
                    end
                    default: begin
                        state_d   = StIdle;
                        count_d   = '0;
                        timeout_d = 1'b0;
                    end
                endcase
            end
        end

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                state_q   <= StIdle;
                count_q   <= '0;
                timeout_q <= 1'b0;
                pulse_q   <= 1'b0;
            end else begin
                state_q   <= state_d;
                count_q   <= count_d;
                timeout_q <= timeout_d;
                pulse_q   <= pulse_d;
            end
        end

        assign o_count[c*WIDTH +: WIDTH] = count_q;
        assign o_timeout[c]              = timeout_q;
        assign o_pulse[c]                = pulse_q;
    end

`ifdef MULTI_TIMEOUT_IRQ_EN
    logic [CHANNELS-1:0] irq_status_q, irq_status_d;
    logic                irq_q, irq_d;

    // A new pulse wins over an ack landing in the same cycle.
    always_comb begin
        irq_status_d = (irq_status_q & ~i_irq_ack) | (o_pulse & i_irq_mask);
        irq_d        = |irq_status_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            irq_status_q <= '0;
            irq_q        <= 1'b0;
        end else begin
            irq_status_q <= irq_status_d;
            irq_q        <= irq_d;
        end
    end

    assign o_irq_status = irq_status_q;
    assign o_irq        = irq_q;
`endif

endmodule

// File: tb/tb_multi_timeout.sv
// Directed bench for multi_timeout: vector table for the one-shot channel plus hand sequences.
// Covers the IRQ block too when MULTI_TIMEOUT_IRQ_EN is defined.
module tb_multi_timeout;

    localparam int CH = 4;
    localparam int W  = 16;
    localparam int PW = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [PW-1:0]   presc;
    logic [CH-1:0]   enable;
    logic [CH-1:0]   clear;
    logic [CH-1:0]   mode;
    logic [CH*W-1:0] limit;
    logic [CH*W-1:0] count;
    logic [CH-1:0]   timeout;
    logic [CH-1:0]   pulse;
`ifdef MULTI_TIMEOUT_IRQ_EN
    logic [CH-1:0]   irq_mask;
    logic [CH-1:0]   irq_ack;
    logic [CH-1:0]   irq_status;
    logic            irq;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_timeout #(
        .CHANNELS   (CH),
        .WIDTH      (W),
        .PRESC_WIDTH(PW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_presc     (presc),
        .i_enable    (enable),
        .i_clear     (clear),
        .i_mode      (mode),
        .i_limit     (limit),
`ifdef MULTI_TIMEOUT_IRQ_EN
        .i_irq_mask  (irq_mask),
        .i_irq_ack   (irq_ack),
        .o_irq_status(irq_status),
        .o_irq       (irq),
`endif
        .o_count     (count),
        .o_timeout   (timeout),
        .o_pulse     (pulse)
    );

    typedef struct {
        logic        en;
        logic        clr;
        logic [15:0] cnt;
        logic        to;
        logic        pls;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock edge; outputs are then sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] cnt_of(input int c);
        return count[c*W +: W];
    endfunction

    task automatic set_limit(input int c, input logic [15:0] v);
        limit[c*W +: W] = v;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        enable = '0;
        clear  = '0;
        mode   = '0;
        limit  = '0;
        presc  = '0;
`ifdef MULTI_TIMEOUT_IRQ_EN
        irq_mask = '0;
        irq_ack  = '0;
`endif
        step();
        rst = 1'b0;
    endtask

    initial begin
        int n_pulse;
        logic seen;

        // ch0, presc=0, limit 5 one-shot: enable, expire, hold, clear, restart.
        vecs[0] = '{1'b1, 1'b0, 16'd0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'd1, 1'b0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 16'd2, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b0, 16'd3, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'd4, 1'b0, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 16'd5, 1'b1, 1'b1};
        vecs[6] = '{1'b1, 1'b0, 16'd5, 1'b1, 1'b0};
        vecs[7] = '{1'b1, 1'b0, 16'd5, 1'b1, 1'b0};
        vecs[8] = '{1'b1, 1'b1, 16'd0, 1'b0, 1'b0};
        vecs[9] = '{1'b1, 1'b0, 16'd1, 1'b0, 1'b0};

        do_reset();
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_timeout", 64'(timeout), 64'd0);
        chk("reset_pulse", 64'(pulse), 64'd0);

        set_limit(0, 16'd5);
        for (int i = 0; i < 10; i++) begin
            enable[0] = vecs[i].en;
            clear[0]  = vecs[i].clr;
            step();
            chk($sformatf("v%0d_count0", i), 64'(cnt_of(0)), 64'(vecs[i].cnt));
            chk($sformatf("v%0d_timeout", i), 64'(timeout), 64'({3'b000, vecs[i].to}));
            chk($sformatf("v%0d_pulse", i), 64'(pulse), 64'({3'b000, vecs[i].pls}));
        end

        // ch1 periodic, presc=3, limit 4: tick on edges n%4==3, expiry on n%16==15.
        do_reset();
        presc = 8'd3;
        mode  = 4'b0010;
        set_limit(1, 16'd4);
        enable = 4'b0010;
        n_pulse = 0;
        seen    = 1'b0;
        for (int n = 0; n < 80; n++) begin
            step();
            if (pulse[1]) n_pulse++;
            if (timeout[1]) seen = 1'b1;
            chk($sformatf("per_pulse_n%0d", n), 64'(pulse[1]), 64'((n % 16) == 15));
            chk($sformatf("per_count_n%0d", n), 64'(cnt_of(1)), 64'(((n + 1) / 4) % 4));
        end
        chk("per_pulse_total", 64'(n_pulse), 64'd5);
        chk("per_no_timeout", 64'(seen), 64'd0);

        // ch2 limit 10: clear on the expiring tick, then expire 10 ticks later.
        do_reset();
        set_limit(2, 16'd10);
        enable = 4'b0100;
        for (int i = 0; i < 10; i++) step();
        chk("clr_pre_count", 64'(cnt_of(2)), 64'd9);
        clear = 4'b0100;
        step();
        clear = '0;
        chk("clr_tick_count", 64'(cnt_of(2)), 64'd0);
        chk("clr_tick_pulse", 64'(pulse), 64'd0);
        for (int i = 0; i < 9; i++) step();
        chk("clr_re_count", 64'(cnt_of(2)), 64'd9);
        chk("clr_re_nopulse", 64'(pulse), 64'd0);
        step();
        chk("clr_expire_pulse", 64'(pulse), 64'b0100);
        chk("clr_expire_to", 64'(timeout), 64'b0100);
        chk("clr_expire_count", 64'(cnt_of(2)), 64'd10);
        clear = 4'b0100;
        step();
        clear = '0;
        for (int i = 0; i < 3; i++) step();
        chk("dis_pre_count", 64'(cnt_of(2)), 64'd3);
        enable = '0;
        step();
        chk("dis_count", 64'(cnt_of(2)), 64'd0);
        enable = 4'b0100;
        step();
        chk("idle_ignores_tick", 64'(cnt_of(2)), 64'd0);
        step();
        chk("idle_then_run", 64'(cnt_of(2)), 64'd1);

        // ch3: lowering the limit below the count expires on the next tick.
        do_reset();
        set_limit(3, 16'd20);
        enable = 4'b1000;
        for (int i = 0; i < 8; i++) step();
        chk("lim_pre_count", 64'(cnt_of(3)), 64'd7);
        set_limit(3, 16'd3);
        step();
        chk("lim_drop_pulse", 64'(pulse), 64'b1000);
        chk("lim_drop_to", 64'(timeout), 64'b1000);
        chk("lim_drop_count", 64'(cnt_of(3)), 64'd3);
        set_limit(3, 16'd0);
        clear = 4'b1000;
        step();
        clear = '0;
        seen  = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step();
            if (pulse[3] || timeout[3] || (cnt_of(3) != 16'd0)) seen = 1'b1;
        end
        chk("lim_zero_never", 64'(seen), 64'd0);

        // Reset while ch0 EXPIRED and ch1 RUN, then prescaler restart timing.
        do_reset();
        set_limit(0, 16'd2);
        set_limit(1, 16'd100);
        mode   = 4'b0010;
        enable = 4'b0011;
        for (int i = 0; i < 4; i++) step();
        chk("mid_pre_to", 64'(timeout), 64'b0001);
        chk("mid_pre_count1", 64'(cnt_of(1)), 64'd3);
        presc = 8'd2;
        rst   = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_count", 64'(count), 64'd0);
        chk("mid_rst_to", 64'(timeout), 64'd0);
        chk("mid_rst_pulse", 64'(pulse), 64'd0);
        step();
        step();
        chk("mid_no_early_tick", 64'(cnt_of(1)), 64'd0);
        step();
        chk("mid_first_tick1", 64'(cnt_of(1)), 64'd1);
        chk("mid_first_tick0", 64'(cnt_of(0)), 64'd1);

`ifdef MULTI_TIMEOUT_IRQ_EN
        do_reset();
        chk("irq_reset_status", 64'(irq_status), 64'd0);
        chk("irq_reset_irq", 64'(irq), 64'd0);
        irq_mask = 4'b0101;
        for (int c = 0; c < CH; c++) set_limit(c, 16'd1);
        enable = 4'b1111;
        step();
        step();
        chk("irq_all_pulse", 64'(pulse), 64'b1111);
        step();
        chk("irq_status_set", 64'(irq_status), 64'b0101);
        step();
        chk("irq_out", 64'(irq), 64'd1);
        irq_ack = 4'b0001;
        step();
        irq_ack = '0;
        chk("irq_ack0", 64'(irq_status), 64'b0100);
        clear = 4'b0100;
        step();
        clear = '0;
        step();
        chk("irq_ch2_repulse", 64'(pulse), 64'b0100);
        irq_ack = 4'b0100;
        step();
        irq_ack = '0;
        chk("irq_set_wins", 64'(irq_status), 64'b0100);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
